// File: rtl/hit_event_ctrl.sv
// Per-frame collision arbiter: collects sticky shot/ship overlaps during a frame and,
// at frame end, serialises one scored hit per asteroid into the score box add/sum interface.
module hit_event_ctrl #(
    parameter int N_AST     = 8,
    parameter int SUM_W     = 8,
    parameter int V_END     = 480,
    parameter int PTS_LARGE = 20,
    parameter int PTS_MED   = 50,
    parameter int PTS_SMALL = 100
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 enable,
    input  logic [31:0]          pxl_x,
    input  logic [31:0]          pxl_y,
    input  logic                 draw_shot,
    input  logic                 draw_ship,
    input  logic [N_AST-1:0]     draw_ast,
    input  logic [2*N_AST-1:0]   ast_size,
    output logic                 add,
    output logic [SUM_W-1:0]     sum,
    output logic [N_AST-1:0]     ast_hit,
    output logic                 shot_hit,
    output logic                 ship_hit,
    output logic                 busy
);

    typedef enum logic {COLLECT, DISPATCH} state_t;

    localparam logic [31:0] V_END_W = 32'(V_END);

    state_t                 state_reg, state_next;
    logic [31:0]            prev_y_reg;
    logic [N_AST-1:0]       shot_col_reg, shot_col_next;
    logic                   ship_col_reg, ship_col_next;
    logic [N_AST-1:0]       pend_reg, pend_next;
    logic [2*N_AST-1:0]     size_q_reg, size_q_next;
    logic                   first_reg, first_next;
    logic                   add_reg, add_next;
    logic [SUM_W-1:0]       sum_reg, sum_next;
    logic [N_AST-1:0]       ast_hit_reg, ast_hit_next;
    logic                   shot_hit_reg, shot_hit_next;
    logic                   ship_hit_reg, ship_hit_next;

    logic                   frame_tick;
    logic [N_AST-1:0]       sel;
    logic [N_AST-1:0][SUM_W-1:0] pts_tab;
    logic [N_AST-1:0]       pts_valid;
    logic [SUM_W-1:0]       sum_sel;
    logic                   add_sel;

    // Horizontal position plays no part in collision timing; kept for a uniform port list.
    logic unused_pxl_x;
    assign unused_pxl_x = ^pxl_x;

    assign frame_tick = (pxl_y == V_END_W) && (prev_y_reg != V_END_W);

    // Two's-complement trick isolates the lowest pending asteroid.
    assign sel = pend_reg & (~pend_reg + N_AST'(1));

    generate
        for (genvar gi = 0; gi < N_AST; gi++) begin : g_pts
            logic [1:0] code;
            assign code = size_q_reg[2*gi +: 2];
            assign pts_tab[gi] = (code == 2'd0) ? SUM_W'(PTS_LARGE) :
                                 (code == 2'd1) ? SUM_W'(PTS_MED)   :
                                 (code == 2'd2) ? SUM_W'(PTS_SMALL) : '0;
            assign pts_valid[gi] = (code != 2'd3);
        end
    endgenerate

    always_comb begin
        sum_sel = '0;
        for (int i = 0; i < N_AST; i++) begin
            if (sel[i]) begin
                sum_sel = sum_sel | pts_tab[i];
            end
        end
        add_sel = |(sel & pts_valid);
    end

    always_comb begin
        state_next    = state_reg;
        shot_col_next = shot_col_reg;
        ship_col_next = ship_col_reg;
        pend_next     = pend_reg;
        size_q_next   = size_q_reg;
        first_next    = first_reg;
        add_next      = 1'b0;
        sum_next      = '0;
        ast_hit_next  = '0;
        shot_hit_next = 1'b0;
        ship_hit_next = 1'b0;

        // Overlap seen on the tick cycle itself belongs to the next frame.
        if (!enable) begin
            shot_col_next = '0;
            ship_col_next = 1'b0;
        end else if (frame_tick) begin
            shot_col_next = {N_AST{draw_shot}} & draw_ast;
            ship_col_next = draw_ship & (|draw_ast);
        end else begin
            shot_col_next = shot_col_reg | ({N_AST{draw_shot}} & draw_ast);
            ship_col_next = ship_col_reg | (draw_ship & (|draw_ast));
        end

        if (state_reg == DISPATCH) begin
            pend_next     = pend_reg & ~sel;
            add_next      = add_sel;
            sum_next      = sum_sel;
            ast_hit_next  = sel;
            shot_hit_next = first_reg;
            first_next    = 1'b0;
        end

        if (enable && frame_tick) begin
            pend_next     = pend_next | shot_col_reg;
            size_q_next   = ast_size;
            ship_hit_next = ship_col_reg;
        end

        case (state_reg)
            COLLECT: begin
                if (pend_next != '0) begin
                    state_next = DISPATCH;
                    first_next = 1'b1;
                end
            end
            DISPATCH: begin
                if (pend_next == '0) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg    <= COLLECT;
            prev_y_reg   <= '0;
            shot_col_reg <= '0;
            ship_col_reg <= 1'b0;
            pend_reg     <= '0;
            size_q_reg   <= '0;
            first_reg    <= 1'b0;
            add_reg      <= 1'b0;
            sum_reg      <= '0;
            ast_hit_reg  <= '0;
            shot_hit_reg <= 1'b0;
            ship_hit_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prev_y_reg   <= pxl_y;
            shot_col_reg <= shot_col_next;
            ship_col_reg <= ship_col_next;
            pend_reg     <= pend_next;
            size_q_reg   <= size_q_next;
            first_reg    <= first_next;
            add_reg      <= add_next;
            sum_reg      <= sum_next;
            ast_hit_reg  <= ast_hit_next;
            shot_hit_reg <= shot_hit_next;
            ship_hit_reg <= ship_hit_next;
        end
    end

    assign add      = add_reg;
    assign sum      = sum_reg;
    assign ast_hit  = ast_hit_reg;
    assign shot_hit = shot_hit_reg;
    assign ship_hit = ship_hit_reg;
    assign busy     = (state_reg == DISPATCH);

endmodule

// File: tb/tb_hit_event_ctrl.sv
// Directed bench for hit_event_ctrl: each scenario task drives a frame and checks
// the packed output vector {add, sum, ast_hit, shot_hit, ship_hit, busy} cycle by cycle.
module tb_hit_event_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enable;
    logic [31:0] pxl_x;
    logic [31:0] pxl_y;
    logic        draw_shot;
    logic        draw_ship;
    logic [7:0]  draw_ast;
    logic [15:0] ast_size;
    logic        add;
    logic [7:0]  sum;
    logic [7:0]  ast_hit;
    logic        shot_hit;
    logic        ship_hit;
    logic        busy;

    logic [19:0] obs;
    logic [19:0] exp_v;
    int          total = 0;
    int          bad   = 0;

    assign obs = {add, sum, ast_hit, shot_hit, ship_hit, busy};

    hit_event_ctrl dut (
        .clk       (clk),
        .resetN    (resetN),
        .enable    (enable),
        .pxl_x     (pxl_x),
        .pxl_y     (pxl_y),
        .draw_shot (draw_shot),
        .draw_ship (draw_ship),
        .draw_ast  (draw_ast),
        .ast_size  (ast_size),
        .add       (add),
        .sum       (sum),
        .ast_hit   (ast_hit),
        .shot_hit  (shot_hit),
        .ship_hit  (ship_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic overlap(input logic s, input logic sh, input logic [7:0] a, input int n);
        draw_shot = s;
        draw_ship = sh;
        draw_ast  = a;
        repeat (n) tick();
        draw_shot = 1'b0;
        draw_ship = 1'b0;
        draw_ast  = '0;
    endtask

    // Leaves the bench inside the tick cycle T (pxl_y just moved 479 -> 480).
    task automatic frame_end();
        pxl_y = 32'd479;
        tick();
        pxl_y = 32'd480;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            draw_shot = i[0];
            draw_ship = ~i[0];
            draw_ast  = 8'hFF;
            pxl_y     = i[0] ? 32'd480 : 32'd479;
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
            else $display("reset_hold cyc%0d: obs=%h", i, obs);
        end
        draw_shot = 1'b0; draw_ship = 1'b0; draw_ast = '0; pxl_y = 32'd100;
        resetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reset_idle: got %h want %h", obs, exp_v); end
            else $display("reset_idle cyc%0d: obs=%h", i, obs);
        end
    endtask

    task automatic test_single_hit();
        ast_size = 16'h0040;
        overlap(1'b1, 1'b0, 8'h08, 5);
        frame_end();
        tick();
        exp_v = {1'b0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_t1: got %h want %h", obs, exp_v); end
        else $display("single_t1: obs=%h", obs);
        tick();
        exp_v = {1'b1, 8'd50, 8'h08, 1'b1, 1'b0, 1'b0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_t2: got %h want %h", obs, exp_v); end
        else $display("single_t2: obs=%h", obs);
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL single_t3: got %h want %h", obs, exp_v); end
        else $display("single_t3: obs=%h", obs);
        pxl_y = 32'd100;
        tick();
    endtask

    task automatic test_multi_hit();
        logic [19:0] seq_exp [5];
        seq_exp[0] = {1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 1'b1};
        seq_exp[1] = {1'b1, 8'd20,  8'h01, 1'b1, 1'b0, 1'b1};
        seq_exp[2] = {1'b1, 8'd100, 8'h20, 1'b0, 1'b0, 1'b1};
        seq_exp[3] = {1'b0, 8'd0,   8'h40, 1'b0, 1'b0, 1'b0};
        seq_exp[4] = '0;
        ast_size = 16'h3800;
        overlap(1'b1, 1'b0, 8'h61, 3);
        frame_end();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== seq_exp[i]) begin bad++; $display("FAIL multi_t%0d: got %h want %h", i + 1, obs, seq_exp[i]); end
            else $display("multi_t%0d: obs=%h", i + 1, obs);
        end
        pxl_y = 32'd100;
        tick();
    endtask

    task automatic test_ship_crash();
        ast_size = 16'h0000;
        overlap(1'b0, 1'b1, 8'h04, 2);
        frame_end();
        tick();
        exp_v = {1'b0, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ship_t1: got %h want %h", obs, exp_v); end
        else $display("ship_t1: obs=%h", obs);
        tick();
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ship_t2: got %h want %h", obs, exp_v); end
        else $display("ship_t2: obs=%h", obs);
        pxl_y = 32'd100;
        tick();
    endtask

    task automatic test_sticky();
        ast_size = 16'h0000;
        overlap(1'b1, 1'b0, 8'h02, 2);
        frame_end();
        tick();
        tick();
        exp_v = {1'b1, 8'd20, 8'h02, 1'b1, 1'b0, 1'b0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sticky_f1: got %h want %h", obs, exp_v); end
        else $display("sticky_f1: obs=%h", obs);
        pxl_y = 32'd100;
        tick();
        frame_end();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL sticky_f2_c%0d: got %h want %h", i, obs, exp_v); end
            else $display("sticky_f2 cyc%0d: obs=%h", i, obs);
        end
        pxl_y = 32'd100;
        tick();
        // overlap only on the tick cycle
        pxl_y = 32'd479;
        tick();
        pxl_y = 32'd480;
        draw_shot = 1'b1;
        draw_ast  = 8'h10;
        tick();
        draw_shot = 1'b0;
        draw_ast  = '0;
        for (int i = 0; i < 3; i++) begin
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL sticky_edge_c%0d: got %h want %h", i, obs, exp_v); end
            else $display("sticky_edge cyc%0d: obs=%h", i, obs);
            tick();
        end
        pxl_y = 32'd100;
        tick();
        frame_end();
        tick();
        tick();
        exp_v = {1'b1, 8'd20, 8'h10, 1'b1, 1'b0, 1'b0};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sticky_f3: got %h want %h", obs, exp_v); end
        else $display("sticky_f3: obs=%h", obs);
        pxl_y = 32'd100;
        tick();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        overlap(1'b1, 1'b1, 8'h03, 3);
        frame_end();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL enable_off_c%0d: got %h want %h", i, obs, exp_v); end
            else $display("enable_off cyc%0d: obs=%h", i, obs);
        end
        pxl_y  = 32'd100;
        enable = 1'b1;
        tick();
        frame_end();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL enable_on_c%0d: got %h want %h", i, obs, exp_v); end
            else $display("enable_on cyc%0d: obs=%h", i, obs);
        end
        pxl_y = 32'd100;
        tick();
    endtask

    task automatic test_reset_mid_dispatch();
        ast_size = 16'h0000;
        overlap(1'b1, 1'b0, 8'h0F, 2);
        frame_end();
        tick();
        tick();
        exp_v = {1'b1, 8'd20, 8'h01, 1'b1, 1'b0, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rstmid_first: got %h want %h", obs, exp_v); end
        else $display("rstmid_first: obs=%h", obs);
        resetN = 1'b0;
        #1;
        exp_v = '0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rstmid_async: got %h want %h", obs, exp_v); end
        else $display("rstmid_async: obs=%h", obs);
        pxl_y = 32'd100;
        tick();
        tick();
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_v = '0;
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL rstmid_after_c%0d: got %h want %h", i, obs, exp_v); end
            else $display("rstmid_after cyc%0d: obs=%h", i, obs);
        end
    endtask

    initial begin
        resetN    = 1'b0;
        enable    = 1'b1;
        pxl_x     = 32'd0;
        pxl_y     = 32'd100;
        draw_shot = 1'b0;
        draw_ship = 1'b0;
        draw_ast  = '0;
        ast_size  = '0;
        tick();
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_ship_crash();
        test_sticky();
        test_enable();
        test_reset_mid_dispatch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
